// File: rtl/modexp_pkg.sv
// Shared types and default sizes for the modular exponentiation controller.
// The optional leading-zero skip is built when MODEXP_SKIP_LEADING_ZEROS_EN is defined.
package modexp_pkg;

  localparam int MODEXP_WIDTH     = 1024;
  localparam int MODEXP_EXP_WIDTH = 1024;
  localparam int MODEXP_LEN_W     = 11;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Montgomery multiplications issued by the controller
  typedef enum logic [1:0] {
    TOMONT,
    SQR,
    MUL,
    FROMMONT
  } op_t;

endpackage

// File: rtl/modexp_exp_shreg.sv
// Exponent walker: a left-shifting register with the bit under consideration
// at the MSB, plus a count of bits still to be processed.
module modexp_exp_shreg #(
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [EXP_WIDTH-1:0] e_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 shift_i,
  output logic                 bit_o,
  output logic                 last_o,
  output logic                 empty_o
);

  localparam logic [LEN_W:0] FULL = (LEN_W+1)'(EXP_WIDTH);

  logic [EXP_WIDTH-1:0] sh_q;
  logic [LEN_W-1:0]     cnt_q;
  logic [LEN_W:0]       align;

  // Left-justify the used bits so bit e_len-1 lands at the MSB on load
  assign align = FULL - {1'b0, len_i};

  // Load a new exponent, or consume the current MSB bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= e_i << align;
      cnt_q <= len_i;
    end else if (shift_i && (cnt_q != '0)) begin
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end

  assign bit_o   = sh_q[EXP_WIDTH-1];
  assign last_o  = (cnt_q == LEN_W'(1));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Square-and-multiply controller driving one Montgomery multiplier.
// Define MODEXP_SKIP_LEADING_ZEROS_EN to add a SCAN state that skips the
// exponent's leading zeros before the first multiplication.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH     = MODEXP_WIDTH,
  parameter int EXP_WIDTH = MODEXP_EXP_WIDTH,
  parameter int LEN_W     = MODEXP_LEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] m_q, x_q, r2_q, acc_q, xt_q, result_q;
  logic [WIDTH-1:0] acc_d, xt_d;
  logic [WIDTH-1:0] mm_a_q, mm_b_q;
  logic             busy_q, done_q, mm_start_q;
  logic             consume;
  logic             exp_load, exp_shift, exp_bit, exp_last, exp_empty;

  function automatic logic [WIDTH-1:0] sel_a(op_t o, logic [WIDTH-1:0] x,
                                             logic [WIDTH-1:0] acc);
    logic [WIDTH-1:0] v;
    v = (o == TOMONT) ? x : acc;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] sel_b(op_t o, logic [WIDTH-1:0] r2,
                                             logic [WIDTH-1:0] acc,
                                             logic [WIDTH-1:0] xt);
    logic [WIDTH-1:0] v;
    case (o)
      TOMONT:  v = r2;
      SQR:     v = acc;
      MUL:     v = xt;
      default: v = ONE;
    endcase
    return v;
  endfunction

  modexp_exp_shreg #(
    .EXP_WIDTH(EXP_WIDTH),
    .LEN_W    (LEN_W)
  ) u_exp (
    .clk    (clk),
    .reset  (reset),
    .load_i (exp_load),
    .e_i    (in_e),
    .len_i  (in_e_len),
    .shift_i(exp_shift),
    .bit_o  (exp_bit),
    .last_o (exp_last),
    .empty_o(exp_empty)
  );

  // Pick the op that follows the one in flight and the registers it writes
  always_comb begin
    op_d    = FROMMONT;
    consume = 1'b0;
    acc_d   = ((op_q == SQR) || (op_q == MUL)) ? mm_result : acc_q;
    xt_d    = (op_q == TOMONT) ? mm_result : xt_q;
    case (op_q)
      TOMONT: op_d = exp_empty ? FROMMONT : SQR;
      SQR: begin
        if (exp_bit) begin
          op_d = MUL;
        end else begin
          consume = 1'b1;
          op_d    = exp_last ? FROMMONT : SQR;
        end
      end
      MUL: begin
        consume = 1'b1;
        op_d    = exp_last ? FROMMONT : SQR;
      end
      default: op_d = FROMMONT;
    endcase
  end

  assign exp_load = (state_q == IDLE) && start;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  assign exp_shift = ((state_q == WAIT) && mm_done && consume) ||
                     ((state_q == SCAN) && !exp_empty && !exp_bit);
`else
  assign exp_shift = (state_q == WAIT) && mm_done && consume;
`endif

  // Sequencer: capture operands, issue each multiplication, collect results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= TOMONT;
      m_q        <= '0;
      x_q        <= '0;
      r2_q       <= '0;
      acc_q      <= '0;
      xt_q       <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q    <= in_m;
            x_q    <= in_x;
            r2_q   <= in_r2;
            acc_q  <= in_r;
            op_q   <= TOMONT;
            busy_q <= 1'b1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            state_q <= SCAN;
`else
            state_q    <= ISSUE;
            mm_start_q <= 1'b1;
            mm_a_q     <= sel_a(TOMONT, in_x, in_r);
            mm_b_q     <= sel_b(TOMONT, in_r2, in_r, xt_q);
`endif
          end
        end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        SCAN: begin
          if (exp_empty || exp_bit) begin
            state_q    <= ISSUE;
            mm_start_q <= 1'b1;
            mm_a_q     <= sel_a(TOMONT, x_q, acc_q);
            mm_b_q     <= sel_b(TOMONT, r2_q, acc_q, xt_q);
          end
        end
`endif
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (mm_done) begin
            acc_q <= acc_d;
            xt_q  <= xt_d;
            if (op_q == FROMMONT) begin
              result_q <= mm_result;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              op_q       <= op_d;
              mm_a_q     <= sel_a(op_d, x_q, acc_d);
              mm_b_q     <= sel_b(op_d, r2_q, acc_d, xt_d);
              mm_start_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl at WIDTH=8 (R=256) with a behavioural Montgomery
// multiplier of configurable latency and a scoreboard of expected results.
`timescale 1ns/1ps
module tb_modexp_ctrl;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_m = '0, in_x = '0, in_r = '0, in_r2 = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_e_len = '0;
  logic          busy, done, mm_start;
  logic [W-1:0]  result, mm_a, mm_b, mm_m;
  logic [W-1:0]  mm_result;
  logic          mm_done;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_m     (in_m),
    .in_x     (in_x),
    .in_e     (in_e),
    .in_e_len (in_e_len),
    .in_r     (in_r),
    .in_r2    (in_r2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_m     (mm_m),
    .mm_result(mm_result),
    .mm_done  (mm_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int lat = 4;
  int cur_m = 13;
  int op_cnt = 0;
  int done_cnt = 0;
  bit abort_mode = 1'b0;

  typedef struct {
    int res;
    int cyc;
    int ops0;
    int nops;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int m;
    int x;
    int e;
    int len;
    int lat;
    int res;
    bit restart;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // a*b*R^-1 mod m with R = 256
  function automatic int mont(int a, int b, int m);
    int rinv = 0;
    for (int k = m - 1; k >= 1; k--) if (((256 * k) % m) == 1) rinv = k;
    return (((a * b) % m) * rinv) % m;
  endfunction

  function automatic int lead_zeros(int e, int len);
    int z = 0;
    for (int k = len - 1; k >= 0; k--) begin
      if (((e >> k) & 1) == 1) break;
      z++;
    end
    return z;
  endfunction

  function automatic int expected_ops(int e, int len);
    int n = 2;
    for (int k = len - 1; k >= 0; k--) n += 1 + ((e >> k) & 1);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    n -= lead_zeros(e, len);
`endif
    return n;
  endfunction

  function automatic int scan_cycles(int e, int len);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    return lead_zeros(e, len) + 1;
`else
    return (e & 0) + (len & 0);
`endif
  endfunction

  // Behavioural multiplier: answers L cycles after each mm_start
  initial begin
    int pend;
    logic [W-1:0] cap_a, cap_b;
    pend = 0;
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (!abort_mode) begin
            chk("mm_a_stable", mm_a, cap_a);
            chk("mm_b_stable", mm_b, cap_b);
          end
          mm_result = W'(mont(cap_a, cap_b, cur_m));
          mm_done = 1'b1;
        end
      end
      if (mm_start) begin
        op_cnt++;
        chk("mm_m", mm_m, cur_m);
        cap_a = mm_a;
        cap_b = mm_b;
        pend = lat;
      end
    end
  end

  // Result monitor: every done is matched against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          $display("done: result=%0d expected=%0d cycle=%0d expected_cycle=%0d ops=%0d expected_ops=%0d",
                   result, e.res, cyc, e.cyc, op_cnt - e.ops0, e.nops);
          chk("result", result, e.res);
          chk("done_cycle", cyc, e.cyc);
          chk("op_count", op_cnt - e.ops0, e.nops);
        end
      end
    end
  end

  // Drive one start request at a negedge; optionally register its expectation
  task automatic kick(vec_t v, bit push);
    exp_t e;
    int r, n;
    cur_m = v.m;
    lat = v.lat;
    r = 256 % v.m;
    in_m = W'(v.m);
    in_x = W'(v.x);
    in_e = EW'(v.e);
    in_e_len = LW'(v.len);
    in_r = W'(r);
    in_r2 = W'((r * r) % v.m);
    start = 1'b1;
    n = expected_ops(v.e, v.len);
    e.res = v.res;
    e.cyc = cyc + n * (v.lat + 1) + 1 + scan_cycles(v.e, v.len);
    e.ops0 = op_cnt;
    e.nops = n;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_m = W'($urandom);
    in_x = W'($urandom);
    in_e = EW'($urandom);
    in_e_len = LW'($urandom_range(0, 8));
    in_r = W'($urandom);
    in_r2 = W'($urandom);
  endtask

  task automatic run_vec(vec_t v);
    int d0, t;
    d0 = done_cnt;
    kick(v, 1'b1);
    chk("busy_running", busy, 1);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
      start = (v.restart && t == 3);
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, required one", t);
    end
    repeat (6) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
    chk("result_held", result, v.res);
  endtask

  initial begin
    int d0, o0;
    vecs[0] = '{m: 13,  x: 2, e: 5,   len: 3, lat: 4, res: 6,  restart: 1'b0};
    vecs[1] = '{m: 13,  x: 7, e: 0,   len: 0, lat: 4, res: 1,  restart: 1'b0};
    vecs[2] = '{m: 251, x: 3, e: 250, len: 8, lat: 4, res: 1,  restart: 1'b0};
    vecs[3] = '{m: 251, x: 3, e: 250, len: 8, lat: 1, res: 1,  restart: 1'b0};
    vecs[4] = '{m: 251, x: 3, e: 250, len: 8, lat: 9, res: 1,  restart: 1'b0};
    vecs[5] = '{m: 13,  x: 2, e: 5,   len: 8, lat: 3, res: 6,  restart: 1'b0};
    vecs[6] = '{m: 251, x: 2, e: 255, len: 8, lat: 2, res: 32, restart: 1'b0};
    vecs[7] = '{m: 13,  x: 0, e: 3,   len: 2, lat: 2, res: 0,  restart: 1'b0};
    vecs[8] = '{m: 13,  x: 2, e: 5,   len: 3, lat: 4, res: 6,  restart: 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_mm_start", mm_start, 0);
    chk("reset_mm_a", mm_a, 0);
    chk("reset_mm_b", mm_b, 0);
    chk("reset_mm_m", mm_m, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a multiplication; the late mm_done must be ignored
    abort_mode = 1'b1;
    kick('{m: 13, x: 2, e: 5, len: 3, lat: 6, res: 6, restart: 1'b0}, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_mm_a", mm_a, 0);
    d0 = done_cnt;
    o0 = op_cnt;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_issue", op_cnt - o0, 0);
    chk("abort_idle_busy", busy, 0);
    abort_mode = 1'b0;

    run_vec(vecs[0]);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
